mc_ctrl_fsm: RTL and testbench

- Multicycle main controller for the 32-bit CPU datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives the 3-bit ALUctr code consumed by the ALU, plus all datapath mux selects and write enables.
- Observes the ALU Zero and Overflow flags to resolve branches and overflow handling.

---
 rtl/mc_ctrl_fsm.sv | 254 +++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
// Optional overflow trap (EXC state, exc port) enabled by defining OVERFLOW_TRAP_EN.
module mc_ctrl_fsm #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       ior_d,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_ctr,
  output logic [3:0] state,
  output logic       instr_done,
`ifdef OVERFLOW_TRAP_EN
  output logic       exc,
`endif
  output logic       err
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
`ifdef OVERFLOW_TRAP_EN
    S_EXC      = 4'd13,
`endif
    S_ERR      = 4'd14
  } state_e;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] pc_src;
    logic       ior_d;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_ctr;
    logic       instr_done;
    logic       err;
  } ctrl_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADDU = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUBU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   funct_legal;

  always_comb begin
    unique case (funct)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_OR, F_SLT, F_SLTU: funct_legal = 1'b1;
      default:                                           funct_legal = 1'b0;
    endcase
  end

  // NOTE: every signal written in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_R:             state_d = funct_legal ? S_EXEC_R : S_ERR;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ORI, OP_ADDIU: state_d = S_EXEC_I;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_ERR;
        endcase
      end
      S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_EXEC_R: begin
        state_d = S_WB_R;
`ifdef OVERFLOW_TRAP_EN
        if (overflow && (funct == F_ADD || funct == F_SUB)) state_d = S_EXC;
`endif
      end
      S_EXEC_I: state_d = S_WB_I;
      S_MEM_WB, S_MEM_WR, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
      S_EXC:    state_d = S_FETCH;
`endif
      S_ERR:    state_d = HALT_ON_ILLEGAL ? S_ERR : S_FETCH;
      default:  state_d = S_RST;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with state_q.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.ir_wr     = 1'b1;
        ctrl_d.pc_wr     = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = 2'b11;
        ctrl_d.ext_op    = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.ext_op    = 1'b1;
      end
      S_MEM_RD: ctrl_d.ior_d = 1'b1;
      S_MEM_WB: begin
        ctrl_d.reg_wr     = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.ior_d      = 1'b1;
        ctrl_d.mem_wr     = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a = 1'b1;
        case (funct)
          F_ADD:   ctrl_d.alu_ctr = ALU_ADD;
          F_SUB:   ctrl_d.alu_ctr = ALU_SUB;
          F_SUBU:  ctrl_d.alu_ctr = ALU_SUBU;
          F_OR:    ctrl_d.alu_ctr = ALU_OR;
          F_SLT:   ctrl_d.alu_ctr = ALU_SLT;
          F_SLTU:  ctrl_d.alu_ctr = ALU_SLTU;
          default: ctrl_d.alu_ctr = ALU_ADDU;
        endcase
      end
      S_WB_R: begin
        ctrl_d.reg_wr     = 1'b1;
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.ext_op    = (op != OP_ORI);
        ctrl_d.alu_ctr   = (op == OP_ORI) ? ALU_OR : ALU_ADDU;
      end
      S_WB_I: begin
        ctrl_d.reg_wr     = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a  = 1'b1;
        ctrl_d.alu_ctr    = ALU_SUBU;
        ctrl_d.pc_wr_cond = 1'b1;
        ctrl_d.pc_src     = 2'b01;
        ctrl_d.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_wr      = 1'b1;
        ctrl_d.pc_src     = 2'b10;
        ctrl_d.instr_done = 1'b1;
      end
`ifdef OVERFLOW_TRAP_EN
      S_EXC:   ctrl_d.instr_done = 1'b1;
`endif
      S_ERR:   ctrl_d.err = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  logic exc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exc_q <= 1'b0;
    else     exc_q <= (state_d == S_EXC);
  end
  assign exc = exc_q;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  assign pc_en      = ctrl_q.pc_wr | (ctrl_q.pc_wr_cond & zero);
  assign pc_src     = ctrl_q.pc_src;
  assign ior_d      = ctrl_q.ior_d;
  assign mem_wr     = ctrl_q.mem_wr;
  assign ir_wr      = ctrl_q.ir_wr;
  assign reg_wr     = ctrl_q.reg_wr;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign ext_op     = ctrl_q.ext_op;
  assign alu_ctr    = ctrl_q.alu_ctr;
  assign instr_done = ctrl_q.instr_done;
  assign err        = ctrl_q.err;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class state by state against hand-built control words.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, overflow;
  logic       pc_en, ior_d, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a, ext_op;
  logic       instr_done, err;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_ctr;
  logic [3:0] state;
`ifdef OVERFLOW_TRAP_EN
  logic       exc;
`endif

  int n_vec = 0;
  int n_err = 0;

  mc_ctrl_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .pc_en(pc_en), .pc_src(pc_src), .ior_d(ior_d), .mem_wr(mem_wr), .ir_wr(ir_wr),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_ctr(alu_ctr), .state(state),
    .instr_done(instr_done),
`ifdef OVERFLOW_TRAP_EN
    .exc(exc),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Control word: pc_en pc_src ior_d mem_wr ir_wr reg_wr reg_dst mem_to_reg alu_src_a alu_src_b ext_op alu_ctr instr_done err
  logic [17:0] ctrl_vec;
  assign ctrl_vec = {pc_en, pc_src, ior_d, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg,
                     alu_src_a, alu_src_b, ext_op, alu_ctr, instr_done, err};

  localparam logic [17:0] C_RST       = 18'b0_00_0_0_0_0_0_0_0_00_0_000_0_0;
  localparam logic [17:0] C_FETCH     = 18'b1_00_0_0_1_0_0_0_0_01_0_000_0_0;
  localparam logic [17:0] C_DEC       = 18'b0_00_0_0_0_0_0_0_0_11_1_000_0_0;
  localparam logic [17:0] C_MADDR     = 18'b0_00_0_0_0_0_0_0_1_10_1_000_0_0;
  localparam logic [17:0] C_MRD       = 18'b0_00_1_0_0_0_0_0_0_00_0_000_0_0;
  localparam logic [17:0] C_MWB       = 18'b0_00_0_0_0_1_0_1_0_00_0_000_1_0;
  localparam logic [17:0] C_MWR       = 18'b0_00_1_1_0_0_0_0_0_00_0_000_1_0;
  localparam logic [17:0] C_EXR_ADDU  = 18'b0_00_0_0_0_0_0_0_1_00_0_000_0_0;
  localparam logic [17:0] C_EXR_ADD   = 18'b0_00_0_0_0_0_0_0_1_00_0_001_0_0;
  localparam logic [17:0] C_EXR_SUB   = 18'b0_00_0_0_0_0_0_0_1_00_0_101_0_0;
  localparam logic [17:0] C_EXR_SLT   = 18'b0_00_0_0_0_0_0_0_1_00_0_111_0_0;
  localparam logic [17:0] C_EXR_SLTU  = 18'b0_00_0_0_0_0_0_0_1_00_0_110_0_0;
  localparam logic [17:0] C_WBR       = 18'b0_00_0_0_0_1_1_0_0_00_0_000_1_0;
  localparam logic [17:0] C_EXI_ORI   = 18'b0_00_0_0_0_0_0_0_1_10_0_010_0_0;
  localparam logic [17:0] C_EXI_ADDIU = 18'b0_00_0_0_0_0_0_0_1_10_1_000_0_0;
  localparam logic [17:0] C_WBI       = 18'b0_00_0_0_0_1_0_0_0_00_0_000_1_0;
  localparam logic [17:0] C_BR_T      = 18'b1_01_0_0_0_0_0_0_1_00_0_100_1_0;
  localparam logic [17:0] C_BR_N      = 18'b0_01_0_0_0_0_0_0_1_00_0_100_1_0;
  localparam logic [17:0] C_JMP       = 18'b1_10_0_0_0_0_0_0_0_00_0_000_1_0;
  localparam logic [17:0] C_EXC       = 18'b0_00_0_0_0_0_0_0_0_00_0_000_1_0;
  localparam logic [17:0] C_ERR       = 18'b0_00_0_0_0_0_0_0_0_00_0_000_0_1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Compare state and control word now, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [17:0] ctl);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctrl"}, 32'(ctrl_vec), 32'(ctl));
`ifdef OVERFLOW_TRAP_EN
    check({tag, ".exc"}, 32'(exc), 32'(st == 4'd13));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
    op    = o;
    funct = f;
  endtask

  initial begin
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    #12;
    check("rst.state", 32'(state), 32'd0);
    check("rst.ctrl", 32'(ctrl_vec), 32'(C_RST));
    rst = 1'b0;
    #1;
    step("rst_rel", 4'd0, C_RST);

    set_instr(6'b000000, 6'b100010);
    step("sub.f", 4'd1, C_FETCH);
    step("sub.d", 4'd2, C_DEC);
    step("sub.x", 4'd7, C_EXR_SUB);
    step("sub.w", 4'd8, C_WBR);

    set_instr(6'b100011, 6'b000000);
    step("lw.f", 4'd1, C_FETCH);
    step("lw.d", 4'd2, C_DEC);
    step("lw.a", 4'd3, C_MADDR);
    step("lw.r", 4'd4, C_MRD);
    step("lw.w", 4'd5, C_MWB);

    set_instr(6'b101011, 6'b000000);
    step("sw.f", 4'd1, C_FETCH);
    step("sw.d", 4'd2, C_DEC);
    step("sw.a", 4'd3, C_MADDR);
    step("sw.w", 4'd6, C_MWR);

    set_instr(6'b000100, 6'b000000);
    step("beqt.f", 4'd1, C_FETCH);
    step("beqt.d", 4'd2, C_DEC);
    zero = 1'b1;
    #1;
    step("beqt.b", 4'd11, C_BR_T);
    zero = 1'b0;

    step("beqn.f", 4'd1, C_FETCH);
    step("beqn.d", 4'd2, C_DEC);
    step("beqn.b", 4'd11, C_BR_N);

    set_instr(6'b000010, 6'b000000);
    step("j.f", 4'd1, C_FETCH);
    step("j.d", 4'd2, C_DEC);
    step("j.j", 4'd12, C_JMP);

    set_instr(6'b001101, 6'b000000);
    step("ori.f", 4'd1, C_FETCH);
    step("ori.d", 4'd2, C_DEC);
    step("ori.x", 4'd9, C_EXI_ORI);
    step("ori.w", 4'd10, C_WBI);

    set_instr(6'b001001, 6'b000000);
    step("addiu.f", 4'd1, C_FETCH);
    step("addiu.d", 4'd2, C_DEC);
    step("addiu.x", 4'd9, C_EXI_ADDIU);
    step("addiu.w", 4'd10, C_WBI);

    set_instr(6'b000000, 6'b101010);
    step("slt.f", 4'd1, C_FETCH);
    step("slt.d", 4'd2, C_DEC);
    step("slt.x", 4'd7, C_EXR_SLT);
    step("slt.w", 4'd8, C_WBR);

    set_instr(6'b000000, 6'b101011);
    step("sltu.f", 4'd1, C_FETCH);
    step("sltu.d", 4'd2, C_DEC);
    step("sltu.x", 4'd7, C_EXR_SLTU);
    step("sltu.w", 4'd8, C_WBR);

    set_instr(6'b000000, 6'b100000);
    overflow = 1'b1;
    step("addov.f", 4'd1, C_FETCH);
    step("addov.d", 4'd2, C_DEC);
    step("addov.x", 4'd7, C_EXR_ADD);
`ifdef OVERFLOW_TRAP_EN
    step("addov.e", 4'd13, C_EXC);
`else
    step("addov.w", 4'd8, C_WBR);
`endif
    overflow = 1'b0;

    // Asynchronous reset landing in the middle of EXEC_R.
    set_instr(6'b000000, 6'b100001);
    step("rstmid.f", 4'd1, C_FETCH);
    step("rstmid.d", 4'd2, C_DEC);
    check("rstmid.x.state", 32'(state), 32'd7);
    check("rstmid.x.ctrl", 32'(ctrl_vec), 32'(C_EXR_ADDU));
    #2 rst = 1'b1;
    #1;
    check("rstmid.async.state", 32'(state), 32'd0);
    check("rstmid.async.ctrl", 32'(ctrl_vec), 32'(C_RST));
    @(posedge clk);
    #1;
    check("rstmid.hold.state", 32'(state), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rstmid.rel.state", 32'(state), 32'd0);
    @(posedge clk);
    #1;

    set_instr(6'b111111, 6'b000000);
    step("ill.f", 4'd1, C_FETCH);
    step("ill.d", 4'd2, C_DEC);
    for (int i = 0; i < 4; i++) step("ill.err", 4'd14, C_ERR);

    rst = 1'b1;
    #1;
    check("final_rst.state", 32'(state), 32'd0);
    check("final_rst.ctrl", 32'(ctrl_vec), 32'(C_RST));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
